// File: rtl/axis_adc_averager_if.sv
// AXI4-Stream channel bundle used on both sides of the ADC averager.
interface axis_adc_averager_if #(
    parameter int DW = 32
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_adc_averager.sv
// Decimating boxcar averager for packed {B, A} ADC sample pairs.
// Sums 2^cur_shift samples per channel and emits the floored mean on a registered stream.
module axis_adc_averager #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int MAX_SHIFT    = 10
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [3:0]           cfg_shift,
    axis_adc_averager_if.slave   s_axis,
    axis_adc_averager_if.master  m_axis,
    output logic [31:0]          sts_overrun
);
    localparam int AW = SAMPLE_WIDTH + MAX_SHIFT;
    localparam int CW = MAX_SHIFT;

    logic signed [AW-1:0]      acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic signed [AW-1:0]      ext_a, ext_b, sum_a, sum_b;
    logic [CW-1:0]             cnt_q, cnt_d, last_cnt;
    logic [3:0]                cur_shift_q, cur_shift_d, shift_eff;
    logic                      m_valid_q, m_valid_d;
    logic [2*SAMPLE_WIDTH-1:0] m_data_q, m_data_d;
    logic [31:0]               ovr_q, ovr_d;
    logic                      hs, blk_end;

    always_comb begin
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        cnt_d       = cnt_q;
        cur_shift_d = cur_shift_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        ovr_d       = ovr_q;

        hs = s_axis.tvalid & ~areset;

        // The block's ratio is taken from cfg_shift only on its first sample.
        if (cnt_q == '0)
            shift_eff = (cfg_shift > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : cfg_shift;
        else
            shift_eff = cur_shift_q;

        last_cnt = ~({CW{1'b1}} << shift_eff);

        ext_a = {{MAX_SHIFT{s_axis.tdata[SAMPLE_WIDTH-1]}}, s_axis.tdata[SAMPLE_WIDTH-1:0]};
        ext_b = {{MAX_SHIFT{s_axis.tdata[2*SAMPLE_WIDTH-1]}},
                 s_axis.tdata[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]};
        sum_a = (cnt_q == '0) ? ext_a : acc_a_q + ext_a;
        sum_b = (cnt_q == '0) ? ext_b : acc_b_q + ext_b;

        blk_end = hs && (cnt_q == last_cnt);

        if (hs) begin
            acc_a_d     = sum_a;
            acc_b_d     = sum_b;
            cur_shift_d = shift_eff;
            cnt_d       = blk_end ? '0 : cnt_q + CW'(1);
        end

        if (blk_end) begin
            if (!m_valid_q || m_axis.tready) begin
                m_valid_d = 1'b1;
                m_data_d  = {SAMPLE_WIDTH'(sum_b >>> shift_eff),
                             SAMPLE_WIDTH'(sum_a >>> shift_eff)};
            end else if (ovr_q != '1) begin
                ovr_d = ovr_q + 32'd1;
            end
        end else if (m_valid_q && m_axis.tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            cnt_q       <= '0;
            cur_shift_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            ovr_q       <= '0;
        end else begin
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            cnt_q       <= cnt_d;
            cur_shift_q <= cur_shift_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            ovr_q       <= ovr_d;
        end
    end

    assign s_axis.tready = ~areset;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign sts_overrun   = ovr_q;
endmodule
